// File: rtl/prm_edge_scan_ctrl_if.sv
// Bundle of obstacle-in, bank-query and mask-out signals for the PRM edge scan sequencer.
// Latency: none, wiring only.
// Backpressure: obs side via obs_ready, mask side via mask_ready; the bank query side has no backpressure.
interface prm_edge_scan_ctrl_if #(
    parameter int CODE_W     = 15,
    parameter int GROUP_W    = 32,
    parameter int NUM_GROUPS = 16
);
    localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    // Obstacle code stream, one frame at a time
    logic [CODE_W-1:0]  obs_code;
    logic               obs_valid;
    logic               obs_last;
    logic               obs_ready;

    // Shared obstacle-check bank; chk_mask answers the query of the previous cycle
    logic               chk_valid;
    logic [CODE_W-1:0]  chk_code;
    logic [GW-1:0]      chk_grp;
    logic [GROUP_W-1:0] chk_mask;

    // Blocked-mask words to the roadmap planner
    logic               mask_valid;
    logic [GROUP_W-1:0] mask_data;
    logic [GW-1:0]      mask_grp;
    logic               mask_last;
    logic               mask_ready;

    // Status
    logic               busy;
    logic               overflow;

    modport slave (
        input  obs_code, obs_valid, obs_last, chk_mask, mask_ready,
        output obs_ready, chk_valid, chk_code, chk_grp,
               mask_valid, mask_data, mask_grp, mask_last, busy, overflow
    );

    modport master (
        output obs_code, obs_valid, obs_last, chk_mask, mask_ready,
        input  obs_ready, chk_valid, chk_code, chk_grp,
               mask_valid, mask_data, mask_grp, mask_last, busy, overflow
    );
endinterface

// File: rtl/prm_edge_scan_ctrl.sv
// Buffers a frame of obstacle codes and scans the shared check bank group by group, OR-ing blocked bits.
// Latency: first word n+2 cycles after the obs_last handshake (n queries, 1 drain, then emit); n+2 per group.
// Backpressure: obs_ready low while scanning/emitting; mask word held stable and no queries while mask_ready is low.
module prm_edge_scan_ctrl #(
    parameter int CODE_W     = 15,
    parameter int GROUP_W    = 32,
    parameter int NUM_GROUPS = 16,
    parameter int MAX_OBS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prm_edge_scan_ctrl_if.slave  bus
);
    localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int OW = $clog2(MAX_OBS + 1);
    localparam int IW = (MAX_OBS > 1) ? $clog2(MAX_OBS) : 1;

    localparam logic [OW-1:0] N_FULL  = OW'(MAX_OBS);
    localparam logic [GW-1:0] G_FINAL = GW'(NUM_GROUPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_EMIT
    } state_t;

    state_t             state_q;
    logic [OW-1:0]      n_q;          // codes held for this frame
    logic [OW-1:0]      k_q;          // next buffer slot to query in this group
    logic [GW-1:0]      g_q;          // group being scanned / emitted
    logic [GROUP_W-1:0] acc_q;        // OR of bank answers for group g_q
    logic               rsp_pend_q;   // a query went out last cycle, so chk_mask is live now

    logic               obs_ready_q;
    logic               chk_valid_q;
    logic [CODE_W-1:0]  chk_code_q;
    logic [GW-1:0]      chk_grp_q;
    logic               mask_valid_q;
    logic [GROUP_W-1:0] mask_data_q;
    logic [GW-1:0]      mask_grp_q;
    logic               mask_last_q;
    logic               busy_q;
    logic               overflow_q;

    logic [CODE_W-1:0]  obs_buf [MAX_OBS];

    logic               obs_hs;
    logic               buf_we;
    logic [IW-1:0]      buf_wa;

    assign obs_hs = bus.obs_valid & obs_ready_q;

    // Slot 0 on the opening code of a frame; once the buffer is full extra codes are dropped.
    always_comb begin
        buf_we = 1'b0;
        buf_wa = '0;
        if (obs_hs) begin
            if (state_q == ST_IDLE) begin
                buf_we = 1'b1;
                buf_wa = '0;
            end else if (n_q != N_FULL) begin
                buf_we = 1'b1;
                buf_wa = n_q[IW-1:0];
            end
        end
    end

    // Frame code storage; contents only matter below n_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            obs_buf[buf_wa] <= bus.obs_code;
        end
    end

    // Sequencer: load frame, then per group issue n queries, drain one answer, emit one word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            k_q          <= '0;
            g_q          <= '0;
            acc_q        <= '0;
            rsp_pend_q   <= 1'b0;
            obs_ready_q  <= 1'b0;
            chk_valid_q  <= 1'b0;
            chk_code_q   <= '0;
            chk_grp_q    <= '0;
            mask_valid_q <= 1'b0;
            mask_data_q  <= '0;
            mask_grp_q   <= '0;
            mask_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            // The bank answer is only meaningful the cycle after a query left.
            rsp_pend_q <= chk_valid_q;

            case (state_q)
                ST_IDLE: begin
                    obs_ready_q <= 1'b1;
                    if (obs_hs) begin
                        overflow_q <= 1'b0;
                        n_q        <= OW'(1);
                        if (bus.obs_last) begin
                            // One-code frame: slot 0 is being written now, so query the live code.
                            state_q     <= ST_SCAN;
                            obs_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            g_q         <= '0;
                            acc_q       <= '0;
                            k_q         <= OW'(1);
                            chk_valid_q <= 1'b1;
                            chk_code_q  <= bus.obs_code;
                            chk_grp_q   <= '0;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    if (obs_hs) begin
                        if (n_q == N_FULL) begin
                            overflow_q <= 1'b1;
                        end else begin
                            n_q <= n_q + OW'(1);
                        end
                        if (bus.obs_last) begin
                            state_q     <= ST_SCAN;
                            obs_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                            g_q         <= '0;
                            acc_q       <= '0;
                            k_q         <= OW'(1);
                            chk_valid_q <= 1'b1;
                            chk_code_q  <= obs_buf[0];
                            chk_grp_q   <= '0;
                        end
                    end
                end

                ST_SCAN: begin
                    if (rsp_pend_q) begin
                        acc_q <= acc_q | bus.chk_mask;
                    end
                    if (k_q < n_q) begin
                        chk_valid_q <= 1'b1;
                        chk_code_q  <= obs_buf[k_q[IW-1:0]];
                        k_q         <= k_q + OW'(1);
                    end else begin
                        chk_valid_q <= 1'b0;
                        // Drain cycle: the last answer is folded straight into the emitted word.
                        if (rsp_pend_q && !chk_valid_q) begin
                            state_q      <= ST_EMIT;
                            mask_valid_q <= 1'b1;
                            mask_data_q  <= acc_q | bus.chk_mask;
                            mask_grp_q   <= g_q;
                            mask_last_q  <= (g_q == G_FINAL);
                        end
                    end
                end

                ST_EMIT: begin
                    if (bus.mask_ready) begin
                        mask_valid_q <= 1'b0;
                        if (mask_last_q) begin
                            state_q     <= ST_IDLE;
                            obs_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            state_q     <= ST_SCAN;
                            g_q         <= g_q + GW'(1);
                            acc_q       <= '0;
                            k_q         <= OW'(1);
                            chk_valid_q <= 1'b1;
                            chk_code_q  <= obs_buf[0];
                            chk_grp_q   <= g_q + GW'(1);
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.obs_ready  = obs_ready_q;
    assign bus.chk_valid  = chk_valid_q;
    assign bus.chk_code   = chk_code_q;
    assign bus.chk_grp    = chk_grp_q;
    assign bus.mask_valid = mask_valid_q;
    assign bus.mask_data  = mask_data_q;
    assign bus.mask_grp   = mask_grp_q;
    assign bus.mask_last  = mask_last_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;

endmodule
